// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer alarm scheduler.
package timer_sched_pkg;

  localparam logic [1:0] OP_CANCEL   = 2'd0;
  localparam logic [1:0] OP_ONESHOT  = 2'd1;
  localparam logic [1:0] OP_PERIODIC = 2'd2;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_ARMED   = 2'd1,
    CH_PENDING = 2'd2
  } ch_state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the channel after ptr_i.
module timer_rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int unsigned  NUM_CH = 4,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned     cand;
    logic [CH_W-1:0] sel;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    sel     = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = (32'(ptr_i) + k) % NUM_CH;
      sel  = CH_W'(cand);
      if (!valid_o && req_i[sel]) begin
        valid_o    = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// Multi-channel wrap-safe alarm scheduler with a round-robin valid/ready event stream.
// Optional build macro TIMER_SCHED_OVERRUN_EN adds sticky periodic-overrun detection.
module timer_alarm_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned  TIME_SIZE = 32,
  parameter int unsigned  NUM_CH    = 4,
  localparam int unsigned CH_W      = ch_width(NUM_CH)
) (
  input  logic                 clk_clock,
  input  logic                 rst,
  input  logic [TIME_SIZE-1:0] count_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [1:0]           cfg_op_i,
  input  logic [TIME_SIZE-1:0] cfg_delta_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [CH_W-1:0]      evt_ch_o,
  output logic [TIME_SIZE-1:0] evt_time_o,
  output logic [NUM_CH-1:0]    armed_o,
  output logic [NUM_CH-1:0]    overrun_o
);

  ch_state_e            state_q    [NUM_CH];
  ch_state_e            state_d    [NUM_CH];
  logic [TIME_SIZE-1:0] deadline_q [NUM_CH];
  logic [TIME_SIZE-1:0] deadline_d [NUM_CH];
  logic [TIME_SIZE-1:0] period_q   [NUM_CH];
  logic [TIME_SIZE-1:0] period_d   [NUM_CH];
  logic [NUM_CH-1:0]    periodic_q, periodic_d;

  logic                 evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]      evt_ch_q, evt_ch_d;
  logic [TIME_SIZE-1:0] evt_time_q, evt_time_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;

  logic                 hs;
  logic                 cfg_fire;
  logic [TIME_SIZE-1:0] delta_eff;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    gnt;
  logic [CH_W-1:0]      gnt_idx;
  logic                 gnt_valid;

`ifdef TIMER_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0]    overrun_q, overrun_d;
  assign overrun_o = overrun_q;
`else
  assign overrun_o = '0;
`endif

  // Reached when (now - dl) is non-negative in two's complement.
  function automatic logic reached(input logic [TIME_SIZE-1:0] now,
                                   input logic [TIME_SIZE-1:0] dl);
    logic [TIME_SIZE-1:0] diff;
    diff = now - dl;
    return ~diff[TIME_SIZE-1];
  endfunction

  assign hs          = evt_valid_q & evt_ready_i;
  assign cfg_ready_o = ~(cfg_valid_i & evt_valid_q & (cfg_ch_i == evt_ch_q) & ~evt_ready_i);
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign delta_eff   = (cfg_delta_i == '0) ? TIME_SIZE'(1) : cfg_delta_i;

  // A channel being reconfigured this cycle must not be granted with stale state.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      req[c]     = (state_q[c] == CH_PENDING) && !(cfg_fire && (cfg_ch_i == CH_W'(c)));
      armed_o[c] = (state_q[c] != CH_IDLE);
    end
  end

  timer_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_comb begin
    logic [TIME_SIZE-1:0] reload;
    reload     = '0;
    periodic_d = periodic_q;
`ifdef TIMER_SCHED_OVERRUN_EN
    overrun_d  = overrun_q;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c]    = state_q[c];
      deadline_d[c] = deadline_q[c];
      period_d[c]   = period_q[c];
      if (cfg_fire && (cfg_ch_i == CH_W'(c))) begin
        case (cfg_op_i)
          OP_CANCEL: begin
            state_d[c] = CH_IDLE;
`ifdef TIMER_SCHED_OVERRUN_EN
            overrun_d[c] = 1'b0;
`endif
          end
          OP_ONESHOT, OP_PERIODIC: begin
            state_d[c]    = CH_ARMED;
            deadline_d[c] = count_i + delta_eff;
            period_d[c]   = delta_eff;
            periodic_d[c] = (cfg_op_i == OP_PERIODIC);
`ifdef TIMER_SCHED_OVERRUN_EN
            overrun_d[c] = 1'b0;
`endif
          end
          default: ;
        endcase
      end else if (hs && (evt_ch_q == CH_W'(c))) begin
        if (periodic_q[c]) begin
          reload        = deadline_q[c] + period_q[c];
          deadline_d[c] = reload;
          state_d[c]    = CH_ARMED;
`ifdef TIMER_SCHED_OVERRUN_EN
          if (reached(count_i, reload)) begin
            state_d[c]   = CH_PENDING;
            overrun_d[c] = 1'b1;
          end
`endif
        end else begin
          state_d[c] = CH_IDLE;
        end
      end else if ((state_q[c] == CH_ARMED) && reached(count_i, deadline_q[c])) begin
        state_d[c] = CH_PENDING;
      end
    end
  end

  // Presented event holds until handshake; a new grant waits for the following cycle.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_time_d  = evt_time_q;
    ptr_d       = ptr_q;
    if (hs) begin
      evt_valid_d = 1'b0;
      ptr_d       = evt_ch_q;
    end else if (!evt_valid_q && gnt_valid) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = gnt_idx;
      evt_time_d  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (gnt[c]) evt_time_d = evt_time_d | deadline_q[c];
      end
    end
  end

  always_ff @(posedge clk_clock or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]    <= CH_IDLE;
        deadline_q[c] <= '0;
        period_q[c]   <= '0;
      end
      periodic_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_time_q  <= '0;
      ptr_q       <= '0;
`ifdef TIMER_SCHED_OVERRUN_EN
      overrun_q   <= '0;
`endif
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]    <= state_d[c];
        deadline_q[c] <= deadline_d[c];
        period_q[c]   <= period_d[c];
      end
      periodic_q  <= periodic_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_time_q  <= evt_time_d;
      ptr_q       <= ptr_d;
`ifdef TIMER_SCHED_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_ch_o    = evt_ch_q;
  assign evt_time_o  = evt_time_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Self-checking bench for timer_alarm_sched: reference model plus directed scenarios.
module tb_timer_alarm_sched;

  localparam int TS  = 32;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_PEND = 2;
`ifdef TIMER_SCHED_OVERRUN_EN
  localparam bit OVR_EXP = 1'b1;
`else
  localparam bit OVR_EXP = 1'b0;
`endif

  logic          clk_clock = 1'b0;
  logic          rst = 1'b0;
  logic [TS-1:0] count_i = '0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [CW-1:0] cfg_ch_i = '0;
  logic [1:0]    cfg_op_i = '0;
  logic [TS-1:0] cfg_delta_i = '0;
  logic          evt_valid_o;
  logic          evt_ready_i = 1'b1;
  logic [CW-1:0] evt_ch_o;
  logic [TS-1:0] evt_time_o;
  logic [NCH-1:0] armed_o;
  logic [NCH-1:0] overrun_o;

  timer_alarm_sched #(
    .TIME_SIZE (TS),
    .NUM_CH    (NCH)
  ) dut (
    .clk_clock   (clk_clock),
    .rst         (rst),
    .count_i     (count_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_op_i    (cfg_op_i),
    .cfg_delta_i (cfg_delta_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_ch_o    (evt_ch_o),
    .evt_time_o  (evt_time_o),
    .armed_o     (armed_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_clock = ~clk_clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel table plus one presented-event slot.
  int            m_st   [NCH];
  logic [TS-1:0] m_dl   [NCH];
  logic [TS-1:0] m_per  [NCH];
  bit            m_perd [NCH];
  bit            m_ovr  [NCH];
  bit            m_ev_valid;
  int            m_ev_ch;
  logic [TS-1:0] m_ev_time;
  int            m_ptr;

  function automatic bit m_reached(input logic [TS-1:0] now, input logic [TS-1:0] dl);
    return $signed(now - dl) >= 0;
  endfunction

  function automatic bit m_cfg_ready();
    return !(cfg_valid_i && m_ev_valid && (int'(cfg_ch_i) == m_ev_ch) && !evt_ready_i);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = S_IDLE; m_dl[i] = '0; m_per[i] = '0; m_perd[i] = 0; m_ovr[i] = 0;
    end
    m_ev_valid = 0; m_ev_ch = 0; m_ev_time = '0; m_ptr = 0;
  endtask

  task automatic m_step();
    bit hs, acc;
    int pick, ch, op;
    logic [TS-1:0] ptime, d;
    hs    = m_ev_valid && evt_ready_i;
    acc   = cfg_valid_i && m_cfg_ready();
    op    = int'(cfg_op_i);
    pick  = -1;
    ptime = '0;
    if (!m_ev_valid) begin
      for (int k = 1; k <= NCH; k++) begin
        ch = (m_ptr + k) % NCH;
        if (pick < 0 && m_st[ch] == S_PEND && !(acc && int'(cfg_ch_i) == ch)) pick = ch;
      end
    end
    if (pick >= 0) ptime = m_dl[pick];
    for (int i = 0; i < NCH; i++) begin
      if (acc && int'(cfg_ch_i) == i) begin
        if (op == 0) begin
          m_st[i] = S_IDLE; m_ovr[i] = 0;
        end else if (op == 1 || op == 2) begin
          d = (cfg_delta_i == 0) ? 1 : cfg_delta_i;
          m_dl[i] = count_i + d; m_per[i] = d; m_perd[i] = (op == 2);
          m_st[i] = S_ARM; m_ovr[i] = 0;
        end
      end else if (hs && m_ev_ch == i) begin
        if (m_perd[i]) begin
          m_dl[i] = m_dl[i] + m_per[i];
          m_st[i] = S_ARM;
`ifdef TIMER_SCHED_OVERRUN_EN
          if (m_reached(count_i, m_dl[i])) begin
            m_st[i] = S_PEND; m_ovr[i] = 1;
          end
`endif
        end else begin
          m_st[i] = S_IDLE;
        end
      end else if (m_st[i] == S_ARM && m_reached(count_i, m_dl[i])) begin
        m_st[i] = S_PEND;
      end
    end
    if (hs) begin
      m_ptr = m_ev_ch; m_ev_valid = 0;
    end
    if (pick >= 0) begin
      m_ev_valid = 1; m_ev_ch = pick; m_ev_time = ptime;
    end
  endtask

  always @(posedge clk_clock or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  logic [NCH-1:0] arm_e, ovr_e;

  always @(negedge clk_clock) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        arm_e[i] = (m_st[i] != S_IDLE);
        ovr_e[i] = m_ovr[i];
      end
      chk("cyc_evt_valid", evt_valid_o, m_ev_valid);
      if (m_ev_valid) begin
        chk("cyc_evt_ch", evt_ch_o, m_ev_ch);
        chk("cyc_evt_time", evt_time_o, m_ev_time);
      end
      chk("cyc_armed", armed_o, arm_e);
      chk("cyc_cfg_ready", cfg_ready_o, m_cfg_ready());
      chk("cyc_overrun", overrun_o, ovr_e);
    end
  end

  task automatic tick();
    @(posedge clk_clock);
    #1;
    count_i = count_i + 1;
  endtask

  task automatic cfg(input int ch, input int op, input logic [TS-1:0] d);
    cfg_valid_i = 1'b1;
    cfg_ch_i    = ch[CW-1:0];
    cfg_op_i    = op[1:0];
    cfg_delta_i = d;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_evt(input int budget);
    int i = 0;
    while (!evt_valid_o && i < budget) begin
      tick();
      i++;
    end
    if (!evt_valid_o) chk("evt_timeout", evt_valid_o, 1);
  endtask

  task automatic rr_round(input int o0, input int o1, input int o2, input int o3);
    int ord [4];
    logic [TS-1:0] c0;
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    c0 = count_i;
    cfg(0, 1, 13);
    cfg(1, 1, 12);
    cfg(2, 1, 11);
    cfg(3, 1, 10);
    for (int e = 0; e < 4; e++) begin
      wait_evt(40);
      chk("rr_ch", evt_ch_o, ord[e]);
      chk("rr_count", count_i, c0 + 15 + 2 * e);
      chk("rr_time", evt_time_o, c0 + 13);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TS-1:0] c0;
    repeat (2) @(posedge clk_clock);
    #1;
    chk("rst_evt_valid", evt_valid_o, 0);
    chk("rst_evt_ch", evt_ch_o, 0);
    chk("rst_evt_time", evt_time_o, 0);
    chk("rst_cfg_ready", cfg_ready_o, 1);
    chk("rst_armed", armed_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst = 1'b1;
    tick();
    tick();

    // One-shot: arm at 100 with delta 10, event visible at count 112.
    count_i = 100;
    cfg(0, 1, 10);
    chk("t1_armed0", armed_o[0], 1);
    wait_evt(40);
    chk("t1_count", count_i, 112);
    chk("t1_ch", evt_ch_o, 0);
    chk("t1_time", evt_time_o, 110);
    tick();
    chk("t1_disarmed", armed_o[0], 0);

    // Periodic ch1, period 5, then cancel.
    c0 = count_i;
    cfg(1, 2, 5);
    for (int e = 0; e < 5; e++) begin
      wait_evt(30);
      chk("per_ch", evt_ch_o, 1);
      chk("per_time", evt_time_o, c0 + 5 * (e + 1));
      chk("per_count", count_i, c0 + 5 * (e + 1) + 2);
      tick();
    end
    cfg(1, 0, 0);
    chk("per_cancel_armed", armed_o[1], 0);
    repeat (20) begin
      tick();
      chk("per_no_evt", evt_valid_o, 0);
    end

    // Wrap-around deadline.
    count_i = 32'hFFFF_FFFA;
    cfg(2, 1, 8);
    wait_evt(30);
    chk("wrap_count", count_i, 4);
    chk("wrap_time", evt_time_o, 2);
    chk("wrap_ch", evt_ch_o, 2);
    tick();

    // Delta 0 behaves as delta 1; leaves the pointer at 3.
    c0 = count_i;
    cfg(3, 1, 0);
    wait_evt(20);
    chk("d0_count", count_i, c0 + 3);
    chk("d0_time", evt_time_o, c0 + 1);
    chk("d0_ch", evt_ch_o, 3);
    tick();

    rr_round(0, 1, 2, 3);
    cfg(1, 1, 2);
    wait_evt(20);
    chk("rr_prep_ch", evt_ch_o, 1);
    tick();
    rr_round(2, 3, 0, 1);

    // Backpressure.
    evt_ready_i = 1'b0;
    c0 = count_i;
    cfg(0, 1, 3);
    cfg(1, 1, 3);
    wait_evt(20);
    chk("bp_ch", evt_ch_o, 0);
    chk("bp_time", evt_time_o, c0 + 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", evt_valid_o, 1);
      chk("bp_ch_stable", evt_ch_o, 0);
      chk("bp_time_stable", evt_time_o, c0 + 3);
      if (i == 5) begin
        cfg_valid_i = 1'b1; cfg_ch_i = 0; cfg_op_i = 1; cfg_delta_i = 50;
        #1;
        chk("bp_cfg_blocked", cfg_ready_o, 0);
      end else if (i == 6) begin
        cfg_ch_i = 2;
        #1;
        chk("bp_cfg_other", cfg_ready_o, 1);
      end else if (i == 7) begin
        cfg_valid_i = 1'b0;
        chk("bp_armed2", armed_o[2], 1);
      end
    end
    cfg(2, 0, 0);
    evt_ready_i = 1'b1;
    wait_evt(5);
    chk("bp_drain0_ch", evt_ch_o, 0);
    chk("bp_drain0_time", evt_time_o, c0 + 3);
    tick();
    wait_evt(10);
    chk("bp_drain1_ch", evt_ch_o, 1);
    chk("bp_drain1_time", evt_time_o, c0 + 4);
    tick();
    chk("bp_all_idle", armed_o, 0);

    // Reset mid-operation drops the pending event.
    evt_ready_i = 1'b0;
    cfg(0, 1, 2);
    wait_evt(10);
    rst = 1'b0;
    #1;
    chk("mrst_evt_valid", evt_valid_o, 0);
    chk("mrst_armed", armed_o, 0);
    tick();
    tick();
    rst = 1'b1;
    evt_ready_i = 1'b1;
    repeat (10) begin
      tick();
      chk("mrst_no_evt", evt_valid_o, 0);
    end

    // Periodic delta 1 held off by backpressure.
    evt_ready_i = 1'b0;
    cfg(0, 2, 1);
    wait_evt(10);
    repeat (5) tick();
    evt_ready_i = 1'b1;
    tick();
    chk("ovr_after_hs", overrun_o[0], OVR_EXP);
    cfg(0, 0, 0);
    chk("ovr_cleared", overrun_o[0], 0);
    chk("ovr_idle", armed_o[0], 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
